// File: rtl/ntt_perm_pkg.sv
// Shared types and address helper for the NTT stage permutation stream.
package ntt_perm_pkg;

  typedef enum logic {W_IDLE, W_FILL} wr_state_t;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

  // Exchange bits lo and hi of addr; both indices must be below 32.
  function automatic logic [31:0] perm_swap_bits(input logic [31:0] addr,
                                                 input logic [31:0] lo,
                                                 input logic [31:0] hi);
    logic [31:0] b_lo;
    logic [31:0] b_hi;
    logic [31:0] mask;
    b_lo = (addr >> lo) & 32'd1;
    b_hi = (addr >> hi) & 32'd1;
    mask = (32'd1 << lo) | (32'd1 << hi);
    return (addr & ~mask) | (b_hi << lo) | (b_lo << hi);
  endfunction

endpackage

// File: rtl/ntt_perm_bank.sv
// One frame bank: DEPTH rows of LANES coefficients, written a row at a time,
// read through LANES independent ports that may address any row and lane.
module ntt_perm_bank
  import ntt_perm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 32,
  parameter int DEPTH      = 32,
  localparam int LW        = $clog2(LANES),
  localparam int CW        = $clog2(DEPTH),
  localparam int ADDR_W    = LW + CW
) (
  input  logic                        clk,
  input  logic                        wr_en_i,
  input  logic [CW-1:0]               wr_row_i,
  input  logic [LANES*DATA_WIDTH-1:0] wr_data_i,
  input  logic [LANES*ADDR_W-1:0]     rd_addr_i,
  output logic [LANES*DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH][LANES];

  // Store a whole incoming beat into the addressed row.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int l = 0; l < LANES; l++) begin
        mem_q[wr_row_i][l] <= wr_data_i[l*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      assign addr = rd_addr_i[gi*ADDR_W +: ADDR_W];
      assign rd_data_o[gi*DATA_WIDTH +: DATA_WIDTH] = mem_q[addr[ADDR_W-1:LW]][addr[LW-1:0]];
    end
  endgenerate

endmodule

// File: rtl/ntt_stage_permutation_stream.sv
// Streaming NTT stage permutation: buffers a frame in one of two ping-pong
// banks and drains it with two coefficient address bits exchanged.
// Optional error reporting is built when PERM_FRAME_ERR_EN is defined;
// otherwise perm_err is tied low.
module ntt_stage_permutation_stream
  import ntt_perm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 32,
  parameter int DEPTH      = 32,
  localparam int ADDR_W    = $clog2(LANES*DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_start,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_W-1:0]           cfg_bit_lo,
  input  logic [ADDR_W-1:0]           cfg_bit_hi,
  output logic                        out_valid,
  output logic                        out_start,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic                        perm_err
);

  localparam int LW = $clog2(LANES);
  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0]     LAST_ROW = CW'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(ADDR_W);

  wr_state_t wr_state_q;
  rd_state_t rd_state_q;
  logic [CW-1:0] wcnt_q, rcnt_q;
  logic wptr_q, rptr_q;
  logic [1:0] full_q, full_d, full_set, full_clr;
  logic [1:0][ADDR_W-1:0] cfg_lo_q, cfg_hi_q;
  logic start_beat, wr_en, cfg_latch;
  logic [CW-1:0] wr_row;
  logic out_valid_q, out_start_q;
  logic [LANES*DATA_WIDTH-1:0] out_data_q;

  assign start_beat = in_valid & in_start;

  // Decode which row (if any) the current beat writes and when a bank completes.
  always_comb begin
    wr_en     = 1'b0;
    wr_row    = '0;
    cfg_latch = 1'b0;
    full_set  = '0;
    case (wr_state_q)
      W_IDLE: begin
        if (start_beat && !full_q[wptr_q]) begin
          wr_en     = 1'b1;
          cfg_latch = 1'b1;
        end
      end
      W_FILL: begin
        if (start_beat) begin
          wr_en     = 1'b1;
          cfg_latch = 1'b1;
        end else if (in_valid) begin
          wr_en  = 1'b1;
          wr_row = wcnt_q;
          if (wcnt_q == LAST_ROW) full_set[wptr_q] = 1'b1;
        end
      end
    endcase
  end

  // Write FSM: fill the write bank row by row, restarting on a fresh start beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      wcnt_q     <= '0;
      wptr_q     <= 1'b0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (cfg_latch) begin
            wr_state_q <= W_FILL;
            wcnt_q     <= CW'(1);
          end
        end
        W_FILL: begin
          if (start_beat) begin
            wcnt_q <= CW'(1);
          end else if (in_valid) begin
            if (wcnt_q == LAST_ROW) begin
              wr_state_q <= W_IDLE;
              wcnt_q     <= '0;
              wptr_q     <= ~wptr_q;
            end else begin
              wcnt_q <= wcnt_q + CW'(1);
            end
          end
        end
      endcase
    end
  end

  // Capture the swap pair alongside the frame it applies to.
  always_ff @(posedge clk) begin
    if (cfg_latch) begin
      cfg_lo_q[wptr_q] <= cfg_bit_lo;
      cfg_hi_q[wptr_q] <= cfg_bit_hi;
    end
  end

  always_comb begin
    full_clr = '0;
    if (rd_state_q == R_DRAIN && rcnt_q == LAST_ROW) full_clr[rptr_q] = 1'b1;
    full_d = (full_q | full_set) & ~full_clr;
  end

  // Bank full flags: set by the writer on the last row, cleared by the reader.
  always_ff @(posedge clk) begin
    if (rst) full_q <= '0;
    else     full_q <= full_d;
  end

  // Read FSM: drain a full bank one row per cycle, chaining into the other bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      rcnt_q     <= '0;
      rptr_q     <= 1'b0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          rcnt_q <= '0;
          if (full_q[rptr_q]) rd_state_q <= R_DRAIN;
        end
        R_DRAIN: begin
          if (rcnt_q == LAST_ROW) begin
            rcnt_q <= '0;
            rptr_q <= ~rptr_q;
            if (!full_q[~rptr_q]) rd_state_q <= R_IDLE;
          end else begin
            rcnt_q <= rcnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  // Source addresses for the row being drained; out-of-range indices mean identity.
  logic [ADDR_W-1:0] cur_lo, cur_hi;
  logic cur_ok;
  logic [LANES*ADDR_W-1:0] rd_addr;
  logic [LANES*DATA_WIDTH-1:0] bank_rd_data [2];

  assign cur_lo = cfg_lo_q[rptr_q];
  assign cur_hi = cfg_hi_q[rptr_q];
  assign cur_ok = (cur_lo < ADDR_LIM) && (cur_hi < ADDR_LIM);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [ADDR_W-1:0] dst_addr;
      assign dst_addr = {rcnt_q, LW'(gi)};
      assign rd_addr[gi*ADDR_W +: ADDR_W] =
        cur_ok ? ADDR_W'(perm_swap_bits(32'(dst_addr), 32'(cur_lo), 32'(cur_hi))) : dst_addr;
    end
    for (gi = 0; gi < 2; gi++) begin : g_bank
      ntt_perm_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .LANES     (LANES),
        .DEPTH     (DEPTH)
      ) u_bank (
        .clk      (clk),
        .wr_en_i  (wr_en && (wptr_q == 1'(gi))),
        .wr_row_i (wr_row),
        .wr_data_i(in_data),
        .rd_addr_i(rd_addr),
        .rd_data_o(bank_rd_data[gi])
      );
    end
  endgenerate

  // Registered output beat; data is zeroed whenever no row is being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= (rd_state_q == R_DRAIN);
      out_start_q <= (rd_state_q == R_DRAIN) && (rcnt_q == '0);
      out_data_q  <= (rd_state_q == R_DRAIN) ? bank_rd_data[rptr_q] : '0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_start = out_start_q;
  assign out_data  = out_data_q;

`ifdef PERM_FRAME_ERR_EN
  logic err_q, err_evt;

  always_comb begin
    err_evt = 1'b0;
    if (wr_state_q == W_IDLE && in_valid && !in_start)       err_evt = 1'b1;
    if (wr_state_q == W_IDLE && start_beat && full_q[wptr_q]) err_evt = 1'b1;
    if (wr_state_q == W_FILL && start_beat)                   err_evt = 1'b1;
    if (cfg_latch && (cfg_bit_lo >= ADDR_LIM || cfg_bit_hi >= ADDR_LIM)) err_evt = 1'b1;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)          err_q <= 1'b0;
    else if (err_evt) err_q <= 1'b1;
  end

  assign perm_err = err_q;
`else
  assign perm_err = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_stage_permutation_stream.sv
// Randomised self-checking bench for ntt_stage_permutation_stream (4 lanes x 4 rows).
module tb_ntt_stage_permutation_stream;

  localparam int DW = 16;
  localparam int L  = 4;
  localparam int D  = 4;
  localparam int N  = L * D;
  localparam int AW = 4;
`ifdef PERM_FRAME_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_start = 1'b0;
  logic [L*DW-1:0] in_data = '0;
  logic [AW-1:0] cfg_bit_lo = '0;
  logic [AW-1:0] cfg_bit_hi = '0;
  logic out_valid, out_start, perm_err;
  logic [L*DW-1:0] out_data;

  ntt_stage_permutation_stream #(.DATA_WIDTH(DW), .LANES(L), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_start(in_start), .in_data(in_data),
    .cfg_bit_lo(cfg_bit_lo), .cfg_bit_hi(cfg_bit_hi), .out_valid(out_valid),
    .out_start(out_start), .out_data(out_data), .perm_err(perm_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [L*DW-1:0] data;
    bit              start;
    int              cyc;
  } beat_t;
  beat_t exp_q[$];

  // Source address for destination a: bit lo and bit hi exchanged, by arithmetic.
  function automatic int ref_src(int a, int lo, int hi);
    int pl, ph, bl, bh;
    if (lo >= AW || hi >= AW) return a;
    pl = 1 << lo;
    ph = 1 << hi;
    bl = (a / pl) % 2;
    bh = (a / ph) % 2;
    return a - bl*pl - bh*ph + bh*pl + bl*ph;
  endfunction

  // Output monitor: one line per observed beat.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        $display("beat cyc=%0d start=%0b data=%h", cyc, out_start, out_data);
        chk("data", out_data, e.data);
        chk("start", 64'(out_start), 64'(e.start));
        chk("beat_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (!rst && out_start) begin
      chk("start_without_valid", 64'(out_start), 64'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_start = 1'b0;
    end
  endtask

  // Drive one frame; a stall of stall_len idle cycles precedes beat stall_at.
  task automatic drive_frame(input int lo, input int hi, input int stall_at, input int stall_len);
    logic [DW-1:0] fr [N];
    beat_t b;
    int extra;
    for (int a = 0; a < N; a++) fr[a] = {12'($urandom), 4'(a)};
    extra = (stall_at > 0 && stall_at < D) ? stall_len : 0;
    for (int c = 0; c < D; c++) begin
      if (c == stall_at) idle(stall_len);
      @(negedge clk);
      in_valid = 1'b1;
      in_start = (c == 0);
      cfg_bit_lo = (c == 0) ? AW'(lo) : AW'($urandom);
      cfg_bit_hi = (c == 0) ? AW'(hi) : AW'($urandom);
      for (int l = 0; l < L; l++) in_data[l*DW +: DW] = fr[c*L + l];
      if (c == 0) begin
        for (int r = 0; r < D; r++) begin
          for (int l = 0; l < L; l++) b.data[l*DW +: DW] = fr[ref_src(r*L + l, lo, hi)];
          b.start = (r == 0);
          b.cyc   = cyc + 1 + D + 1 + extra + r;
          exp_q.push_back(b);
        end
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, hi;
    apply_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_start", 64'(out_start), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_err", 64'(perm_err), 64'd0);

    // Directed swap pairs, including identity and lo > hi.
    drive_frame(0, 2, 0, 0); idle(2);
    drive_frame(0, 1, 0, 0); idle(1);
    drive_frame(3, 3, 0, 0); idle(3);
    drive_frame(1, 3, 0, 0); idle(1);
    drive_frame(3, 0, 0, 0); idle(2);
    wait_drain();

    // Back-to-back frames with different configurations.
    drive_frame(0, 2, 0, 0);
    drive_frame(1, 3, 0, 0);
    idle(1);
    wait_drain();

    // Two-cycle input stall mid-frame.
    drive_frame(1, 2, 2, 2); idle(1);
    wait_drain();

    // Random in-range frames with random stalls and gaps.
    for (int k = 0; k < 24; k++) begin
      lo = $urandom_range(0, AW-1);
      hi = $urandom_range(0, AW-1);
      drive_frame(lo, hi, $urandom_range(0, D), $urandom_range(0, 3));
      idle($urandom_range(0, 3));
    end
    idle(1);
    wait_drain();
    chk("err_clean", 64'(perm_err), 64'd0);

    // Orphan beat while idle: dropped, flagged.
    idle(1);
    @(negedge clk); in_valid = 1'b1; in_start = 1'b0;
    idle(8);
    chk("orphan_no_output", 64'(exp_q.size()), 64'd0);
    chk("err_orphan", 64'(perm_err), 64'(ERR_EN));
    apply_reset();
    chk("err_cleared", 64'(perm_err), 64'd0);

    // Restart: a second start at beat 2 discards the partial frame.
    @(negedge clk); in_valid = 1'b1; in_start = 1'b1; cfg_bit_lo = 0; cfg_bit_hi = 2;
    in_data = {4{16'hdead}};
    @(negedge clk); in_start = 1'b0; in_data = {4{16'hbeef}};
    drive_frame(1, 3, 0, 0); idle(1);
    wait_drain();
    chk("err_restart", 64'(perm_err), 64'(ERR_EN));
    apply_reset();

    // Out-of-range index behaves as identity.
    drive_frame(6, 1, 0, 0); idle(1);
    wait_drain();
    chk("err_cfg_range", 64'(perm_err), 64'(ERR_EN));
    apply_reset();

    // Reset while row 2 is on the output, then a fresh frame.
    drive_frame(0, 2, 0, 0); idle(1);
    for (int i = 0; i < 30 && !out_start; i++) @(negedge clk);
    chk("start_seen", 64'(out_start), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    exp_q.delete();
    rst = 1'b0;
    idle(2);
    chk("post_rst_quiet", 64'(out_valid), 64'd0);
    drive_frame(0, 2, 0, 0); idle(1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
